// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch front end:
// fetch FSM state encodings, default widths and the NOP encoding.
package fetch_pc_unit_pkg;

    localparam int ADDR_W_DEF  = 64;
    localparam int INSTR_W_DEF = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_e;

endpackage : fetch_pc_unit_pkg

// File: rtl/fetch_pc_unit_skid_buf.sv
// Single-entry {pc, instr} skid buffer. Captures a fetched instruction that
// arrived while the decode stage was stalled, so the fetch PC can advance
// without dropping the acknowledged word. Clear wins over load.
module fetch_pc_unit_skid_buf
    import fetch_pc_unit_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  held_pc,
    output logic [INSTR_W-1:0] held_instr
);

    // Entry register: clear empties it, load captures pc/instr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid      <= 1'b0;
            held_pc    <= '0;
            held_instr <= '0;
        end else if (clear) begin
            valid      <= 1'b0;
        end else if (load) begin
            valid      <= 1'b1;
            held_pc    <= load_pc;
            held_instr <= load_instr;
        end
    end

endmodule : fetch_pc_unit_skid_buf

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: holds the PC, issues same-cycle fetch
// requests, and fills the IF/ID pipeline register. if_pc_plus4 feeds the
// IN0 leg of the external next-PC mux whose result returns as redirect_pc.
// Optional feature macro: FETCH_PERF_CNT_EN (adds fetch/flush counters).
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4,
    output logic [INSTR_W-1:0] if_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    output logic               busy
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    fetch_state_e       state;
    fetch_state_e       state_next;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  pc_seq;

    logic               take_fetch;
    logic               load_from_fetch;
    logic               load_from_skid;
    logic               park;
    logic               bubble;

    logic               skid_valid;
    logic [ADDR_W-1:0]  skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    // Sequential PC wraps naturally modulo 2^ADDR_W
    assign pc_seq    = pc + INC;
    assign imem_addr = pc;

    // Next-state, fetch control and PC selection; redirect dominates
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        imem_req        = 1'b0;
        busy            = 1'b0;
        take_fetch      = 1'b0;
        load_from_fetch = 1'b0;
        load_from_skid  = 1'b0;
        park            = 1'b0;
        bubble          = 1'b0;

        case (state)
            FS_IDLE: begin
                state_next = FS_FETCH;
            end
            FS_FETCH: begin
                imem_req = 1'b1;
                if (!redirect_valid) begin
                    if (imem_ack) begin
                        take_fetch = 1'b1;
                        pc_next    = pc_seq;
                        if (stall) begin
                            park       = 1'b1;
                            state_next = FS_HOLD;
                        end else begin
                            load_from_fetch = 1'b1;
                        end
                    end else if (!stall) begin
                        bubble = 1'b1;
                    end
                end
            end
            FS_HOLD: begin
                busy = 1'b1;
                if (!redirect_valid && !stall && skid_valid) begin
                    load_from_skid = 1'b1;
                    state_next     = FS_FETCH;
                end
            end
            default: begin
                state_next = FS_IDLE;
            end
        endcase

        if (redirect_valid) begin
            pc_next    = redirect_pc;
            state_next = FS_FETCH;
        end
    end

    // FSM state and program counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FS_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    fetch_pc_unit_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (park),
        .clear      (redirect_valid | load_from_skid),
        .load_pc    (pc),
        .load_instr (imem_rdata),
        .valid      (skid_valid),
        .held_pc    (skid_pc),
        .held_instr (skid_instr)
    );

    // IF/ID register: flush, load from memory or skid, bubble, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
            if_instr    <= INSTR_W'(NOP_INSTR);
        end else if (redirect_valid) begin
            if_valid    <= 1'b0;
        end else if (load_from_fetch) begin
            if_valid    <= 1'b1;
            if_pc       <= pc;
            if_pc_plus4 <= pc_seq;
            if_instr    <= imem_rdata;
        end else if (load_from_skid) begin
            if_valid    <= 1'b1;
            if_pc       <= skid_pc;
            if_pc_plus4 <= skid_pc + INC;
            if_instr    <= skid_instr;
        end else if (bubble) begin
            if_valid    <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: instructions delivered to decode and flush cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (load_from_fetch || load_from_skid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by
// randomized stall/ack/redirect traffic, all compared against a
// transaction-level model of the fetch front end.
module tb_fetch_pc_unit;

    localparam int          ADDR_W   = 64;
    localparam int          INSTR_W  = 32;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          PC_INC   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               stall = 1'b0;
    logic               redirect_valid = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc = '0;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               if_valid;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pc_plus4;
    logic [INSTR_W-1:0] if_instr;
    logic               busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        perf_fetch_cnt;
    logic [31:0]        perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_pc_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .busy           (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: a PC, an optional parked instruction
    // waiting for decode, and the instruction currently visible to decode.
    logic [63:0]  m_pc;
    bit           m_started;
    bit           m_parked;
    logic [63:0]  m_park_pc;
    logic [31:0]  m_park_instr;
    bit           m_ifv;
    logic [63:0]  m_if_pc;
    logic [63:0]  m_if_pc4;
    logic [31:0]  m_if_instr;
    int unsigned  m_fetch_cnt;
    int unsigned  m_flush_cnt;
    bit           echo_addr = 1'b0;

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_started   = 1'b0;
        m_parked    = 1'b0;
        m_park_pc   = '0;
        m_park_instr= '0;
        m_ifv       = 1'b0;
        m_if_pc     = '0;
        m_if_pc4    = '0;
        m_if_instr  = '0;
        m_fetch_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic deliver(input logic [63:0] pc, input logic [31:0] instr);
        m_ifv      = 1'b1;
        m_if_pc    = pc;
        m_if_pc4   = pc + 64'(PC_INC);
        m_if_instr = instr;
        m_fetch_cnt++;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        if (redirect_valid) begin
            m_pc      = redirect_pc;
            m_parked  = 1'b0;
            m_ifv     = 1'b0;
            m_started = 1'b1;
            m_flush_cnt++;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_parked) begin
            if (!stall) begin
                deliver(m_park_pc, m_park_instr);
                m_parked = 1'b0;
            end
        end else if (imem_ack) begin
            if (!stall) begin
                deliver(m_pc, imem_rdata);
            end else begin
                m_parked     = 1'b1;
                m_park_pc    = m_pc;
                m_park_instr = imem_rdata;
            end
            m_pc = m_pc + 64'(PC_INC);
        end else if (!stall) begin
            m_ifv = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_val("imem_req",    imem_req,    m_started && !m_parked);
        check_val("imem_addr",   imem_addr,   m_pc);
        check_val("busy",        busy,        m_parked);
        check_val("if_valid",    if_valid,    m_ifv);
        check_val("if_pc",       if_pc,       m_if_pc);
        check_val("if_pc_plus4", if_pc_plus4, m_if_pc4);
        check_val("if_instr",    if_instr,    m_if_instr);
`ifdef FETCH_PERF_CNT_EN
        check_val("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
        check_val("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif
    endtask

    // One clock: model update, active edge, then sample 1 time unit later
    task automatic cycle();
        if (echo_addr) imem_rdata = imem_addr[31:0];
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Reset pulse placed between clock edges, released before the next edge
    task automatic async_reset_pulse();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_val("rst_req",   imem_req, 1'b0);
        check_val("rst_busy",  busy,     1'b0);
        check_val("rst_valid", if_valid, 1'b0);
        check_val("rst_addr",  imem_addr, RESET_PC);
        #2;
        rst = 1'b1;
    endtask

    logic [63:0] saved_addr;

    initial begin
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
        check_val("reset_if_pc4", if_pc_plus4, 64'h0);
        rst = 1'b1;

        // Straight-line fetch with data = address
        echo_addr = 1'b1;
        imem_ack  = 1'b1;
        cycle();
        check_val("s1_first_addr", imem_addr, 64'h0);
        check_val("s1_first_req",  imem_req,  1'b1);
        cycle();
        check_val("s1_if_pc",  if_pc,       64'h0);
        check_val("s1_if_pc4", if_pc_plus4, 64'h4);
        cycle();
        check_val("s1_addr8", imem_addr, 64'h8);

        // Stall for 3 cycles while pc=8 is acknowledged
        stall = 1'b1;
        repeat (3) begin
            cycle();
            check_val("s2_busy",  busy,     1'b1);
            check_val("s2_req",   imem_req, 1'b0);
            check_val("s2_hold",  if_pc,    64'h4);
        end
        stall = 1'b0;
        cycle();
        check_val("s2_release_pc", if_pc,     64'h8);
        check_val("s2_resume",     imem_addr, 64'hC);
        cycle();
        check_val("s2_next_pc", if_pc, 64'hC);

        // Redirect concurrent with ack and stall
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF0;
        cycle();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check_val("s3_valid", if_valid,  1'b0);
        check_val("s3_addr",  imem_addr, 64'hFFFF_FFFF_FFFF_FFF0);
        check_val("s3_busy",  busy,      1'b0);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check_val("s4_wrap_pc",  if_pc,       64'hFFFF_FFFF_FFFF_FFFC);
        check_val("s4_wrap_pc4", if_pc_plus4, 64'h0);
        cycle();
        check_val("s4_after_wrap", if_pc, 64'h0);

        // Memory not acknowledging: bubbles, PC steady
        imem_ack   = 1'b0;
        saved_addr = imem_addr;
        repeat (2) begin
            cycle();
            check_val("s5_addr_stable", imem_addr, saved_addr);
            check_val("s5_bubble",      if_valid,  1'b0);
        end

        // Park an instruction, then reset asynchronously while in HOLD
        imem_ack = 1'b1;
        stall    = 1'b1;
        cycle();
        check_val("s6_in_hold", busy, 1'b1);
        async_reset_pulse();
        stall = 1'b0;
        cycle();
        check_val("s6_first_fetch", imem_addr, RESET_PC);
        cycle();
        check_val("s6_first_if_pc", if_pc, RESET_PC);

        // Randomized traffic
        echo_addr = 1'b0;
        for (int i = 0; i < 800; i++) begin
            imem_rdata     = $urandom;
            imem_ack       = ($urandom_range(0, 9) < 7);
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
            else
                redirect_pc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 149) == 0) begin
                async_reset_pulse();
            end else begin
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_pc_unit

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch front end of the 5-stage pipeline. Holds the program counter and issues fetch requests to instruction memory. Presents the fetched instruction in the IF/ID pipeline register. Drives pc_plus4 into the IN0 leg of the 64-bit 2:1 next-PC mux (mux_2); the mux result (branch/jump target) returns as redirect_pc.

Parameters:
ADDR_W, 64, PC/address width
INSTR_W, 32, instruction width
RESET_PC, 64'h0, PC value loaded on reset
PC_INC, 4, sequential PC increment

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  ID stage cannot accept; hold IF/ID register
redirect_valid  in  1  taken branch/jump this cycle
redirect_pc  in  ADDR_W  target PC (from next-PC mux)
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ack  in  1  same-cycle response valid for current imem_addr
imem_rdata  in  INSTR_W  fetched instruction
if_valid  out  1  IF/ID register holds a real instruction
if_pc  out  ADDR_W  PC of if_instr
if_pc_plus4  out  ADDR_W  if_pc + PC_INC (to mux_2 IN0)
if_instr  out  INSTR_W  instruction
busy  out  1  skid buffer occupied (state HOLD)

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=0, skid empty, imem_req=0, busy=0.
- States: IDLE, FETCH, HOLD. Binary encoded.
- IDLE: exactly one cycle after reset release, imem_req=0, then FETCH.
- FETCH: imem_req=1, imem_addr=pc (combinational from the pc register). imem_addr may change on any cycle; ack qualifies only the current address, with no outstanding-transaction memory.
  - No ack: pc holds. If !stall, if_valid<=0 (bubble).
  - Ack and !stall: IF/ID register loads {1, pc, pc+PC_INC, imem_rdata}; pc<=pc+PC_INC. Latency is one edge from ack to if_valid.
  - Ack and stall: imem_rdata and pc go to the skid buffer; pc<=pc+PC_INC; state becomes HOLD; IF/ID register holds.
- HOLD: imem_req=0, busy=1. When stall=0: IF/ID register loads from skid, skid clears, state returns to FETCH.
- Stall with no ack: IF/ID register holds unchanged (if_valid keeps its value).
- Redirect has highest priority in every state:
  - pc<=redirect_pc, skid clears, if_valid<=0, state becomes FETCH (from IDLE or HOLD as well).
  - Any ack in the same cycle is discarded.
  - Flush overrides stall.
- Arithmetic: pc+PC_INC wraps modulo 2^ADDR_W (0xFFFF_FFFF_FFFF_FFFC + 4 = 0). No alignment checking.
- Reset mid-operation: immediate return to the reset values regardless of state.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] (increments per instruction loaded into IF/ID) and perf_flush_cnt[31:0] (increments per redirect cycle). Both reset to 0 and wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared header pipeline_defs.vh holds:
  - state encodings FS_IDLE, FS_FETCH, FS_HOLD
  - ADDR_W and INSTR_W defaults
  - NOP encoding 32'h0
- One natural sub-module: fetch_skid_buf (single-entry {pc, instr} buffer with load/clear/valid).
- The next-PC select stays external in mux_2.

Test Plan:
- Reset release, no stall, imem_ack=1 always, rdata=addr[31:0]: imem_addr 0,4,8 on consecutive FETCH cycles. if_valid rises one edge after the first ack. if_pc=0, if_pc_plus4=4.
- Stall asserted for 3 cycles during an ack at pc=8: busy=1 and imem_req=0 while stalled. IF/ID holds pc=4. After release, if_pc=8, then fetch resumes at 0xC.
- redirect_valid with redirect_pc=64'hFFFFFFFFFFFFFFF0, concurrent with ack and stall: next cycle if_valid=0, imem_addr=…F0, busy=0.
- PC wrap: redirect to …FFFC, ack twice: if_pc=…FFFC with if_pc_plus4=0, then if_pc=0.
- imem_ack=0 for 2 cycles: imem_addr is stable, if_valid=0 (bubbles), pc unchanged.
- Async rst pulse mid-HOLD (not clock-aligned): all outputs return to their reset values immediately. First fetch after release is at RESET_PC. With FETCH_PERF_CNT_EN, both counters read 0.
